hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage core: the successor to the single-cycle stall/flush combiner. It adds support for N stall sources that each request a stall of programmable length, holds the stall through a multi-cycle counter, and handles a busy Execute-stage multicycle unit (mul/div). It also resolves branch redirects into Decode/Execute flushes. It sits beside the pipeline registers and drives their enable/clear lines.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_ctrl_if.sv | 57 +++++
 rtl/hazard_prio_sel.sv | 42 ++++
 rtl/hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and defaults for the pipeline hazard controller.
//   state_t  : controller FSM state (IDLE / STALL)
//   len_t    : per-source stall length at the default field width
//   *_DEF    : default parameter values for NUM_SRC / CNT_W / PERF_W
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam int NUM_SRC_DEF = 4;
  localparam int CNT_W_DEF   = 4;
  localparam int PERF_W_DEF  = 32;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  typedef logic [CNT_W_DEF-1:0] len_t;

endpackage : hazard_pkg

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle between the pipeline (stall sources, Execute unit, branch resolver)
// and the hazard controller.
//   stall_req  [NUM_SRC]        per-source stall request (level)
//   stall_len  [NUM_SRC*CNT_W]  per-source stall length, slice i = [i*CNT_W +: CNT_W]
//   mc_busy_i                   Execute multicycle unit busy
//   redirect_i                  branch/jump redirect resolved in Execute
//   StallF/StallD/StallE        pipeline register holds
//   FlushD/FlushE               pipeline register clears
//   hazard_src [NUM_SRC]        one-hot owner of the current stall
//   busy_o                      controller in STALL state
//   stall_cycles_o, flush_cycles_o, redirect_count_o (only with HAZARD_PERF_EN)
// Modports: master = pipeline side, slave = hazard controller.
// -----------------------------------------------------------------------------
interface hazard_ctrl_if import hazard_pkg::*; #(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int CNT_W   = CNT_W_DEF
`ifdef HAZARD_PERF_EN
  , parameter int PERF_W = PERF_W_DEF
`endif
);

  logic [NUM_SRC-1:0]       stall_req;
  logic [NUM_SRC*CNT_W-1:0] stall_len;
  logic                     mc_busy_i;
  logic                     redirect_i;
  logic                     StallF;
  logic                     StallD;
  logic                     StallE;
  logic                     FlushD;
  logic                     FlushE;
  logic [NUM_SRC-1:0]       hazard_src;
  logic                     busy_o;
`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0]        stall_cycles_o;
  logic [PERF_W-1:0]        flush_cycles_o;
  logic [PERF_W-1:0]        redirect_count_o;
`endif

  modport master (
    output stall_req, stall_len, mc_busy_i, redirect_i,
    input  StallF, StallD, StallE, FlushD, FlushE, hazard_src, busy_o
`ifdef HAZARD_PERF_EN
    , input stall_cycles_o, flush_cycles_o, redirect_count_o
`endif
  );

  modport slave (
    input  stall_req, stall_len, mc_busy_i, redirect_i,
    output StallF, StallD, StallE, FlushD, FlushE, hazard_src, busy_o
`ifdef HAZARD_PERF_EN
    , output stall_cycles_o, flush_cycles_o, redirect_count_o
`endif
  );

endinterface : hazard_ctrl_if

// File: rtl/hazard_prio_sel.sv
// -----------------------------------------------------------------------------
// hazard_prio_sel
// Combinational fixed-priority picker: index 0 is the highest priority.
//   i_req [NUM_SRC]        stall requests
//   i_len [NUM_SRC*CNT_W]  packed per-source stall lengths
//   o_win [NUM_SRC]        one-hot winner (0 when no request)
//   o_len [CNT_W]          winner's length, clamped so 0 reads as 1
// -----------------------------------------------------------------------------
module hazard_prio_sel #(
  parameter int NUM_SRC = 4,
  parameter int CNT_W   = 4
) (
  input  logic [NUM_SRC-1:0]       i_req,
  input  logic [NUM_SRC*CNT_W-1:0] i_len,
  output logic [NUM_SRC-1:0]       o_win,
  output logic [CNT_W-1:0]         o_len
);

  logic [CNT_W-1:0] w_len_arr [NUM_SRC];
  logic [CNT_W-1:0] w_sel_len;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_len_split
    assign w_len_arr[gi] = i_len[gi*CNT_W +: CNT_W];
  end

  // Scan from the lowest priority upward so the lowest asserted index
  // overwrites everything above it.
  always_comb begin
    o_win     = '0;
    w_sel_len = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_win     = '0;
        o_win[i]  = 1'b1;
        w_sel_len = w_len_arr[i];
      end
    end
  end

  assign o_len = (w_sel_len == '0) ? CNT_W'(1) : w_sel_len;

endmodule : hazard_prio_sel

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the 5-stage core. Combines N prioritised
// multi-cycle stall requests, a busy Execute multicycle unit and branch
// redirects into the pipeline register enable/clear lines.
//   clk    pipeline clock
//   rst_n  asynchronous active-low reset; all outputs read 0 while low
//   bus    hazard_ctrl_if.slave (requests in, Stall*/Flush*/hazard_src/busy_o out)
// Optional feature: define HAZARD_PERF_EN to add saturating stall/flush/redirect
// cycle counters (stall_cycles_o, flush_cycles_o, redirect_count_o).
// -----------------------------------------------------------------------------
module hazard_ctrl import hazard_pkg::*; #(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int CNT_W   = CNT_W_DEF
`ifdef HAZARD_PERF_EN
  , parameter int PERF_W = PERF_W_DEF
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  bus
);

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [NUM_SRC-1:0] r_owner, w_owner_next;

  logic [NUM_SRC-1:0] w_win;
  logic [CNT_W-1:0]   w_len;
  logic               w_idle;
  logic               w_req_any;
  logic               w_red;
  logic               w_stall_act;
  logic               w_stall_fd;
  logic               w_flush_e;

  hazard_prio_sel #(
    .NUM_SRC (NUM_SRC),
    .CNT_W   (CNT_W)
  ) u_prio_sel (
    .i_req (bus.stall_req),
    .i_len (bus.stall_len),
    .o_win (w_win),
    .o_len (w_len)
  );

  assign w_idle      = (r_state == IDLE);
  assign w_req_any   = w_idle & (|bus.stall_req);
  // A redirect arriving while Execute is busy cannot be legal; it is dropped.
  assign w_red       = bus.redirect_i & ~bus.mc_busy_i;
  assign w_stall_act = w_req_any | ~w_idle;
  assign w_stall_fd  = (w_stall_act | bus.mc_busy_i) & ~w_red;
  assign w_flush_e   = (w_stall_act & ~bus.mc_busy_i & ~w_red) | w_red;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_owner <= w_owner_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_owner_next = r_owner;
    if (w_red) begin
      // Wrong-path stall is cancelled outright.
      w_state_next = IDLE;
      w_cnt_next   = '0;
      w_owner_next = '0;
    end else if (!bus.mc_busy_i) begin
      unique case (r_state)
        IDLE: begin
          // The first stall cycle is served combinationally from IDLE, so
          // only lengths above 1 need the counter.
          if (w_req_any && (w_len > CNT_W'(1))) begin
            w_state_next = STALL;
            w_cnt_next   = w_len - CNT_W'(1);
            w_owner_next = w_win;
          end
        end
        STALL: begin
          if (r_cnt == CNT_W'(1)) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
            w_owner_next = '0;
          end else begin
            w_cnt_next   = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
          w_owner_next = '0;
        end
      endcase
    end
  end

  // Output logic; every output is held low while reset is asserted.
  always_comb begin
    bus.StallF     = rst_n & w_stall_fd;
    bus.StallD     = rst_n & w_stall_fd;
    bus.StallE     = rst_n & bus.mc_busy_i;
    bus.FlushD     = rst_n & w_red;
    bus.FlushE     = rst_n & w_flush_e;
    bus.busy_o     = rst_n & ~w_idle;
    bus.hazard_src = '0;
    if (rst_n && !w_red) begin
      if (w_req_any)
        bus.hazard_src = w_win;
      else if (!w_idle)
        bus.hazard_src = r_owner;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] r_stall_cycles;
  logic [PERF_W-1:0] r_flush_cycles;
  logic [PERF_W-1:0] r_redirect_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles   <= '0;
      r_flush_cycles   <= '0;
      r_redirect_count <= '0;
    end else begin
      if (w_stall_fd && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + PERF_W'(1);
      if (w_flush_e && (r_flush_cycles != '1))
        r_flush_cycles <= r_flush_cycles + PERF_W'(1);
      if (w_red && (r_redirect_count != '1))
        r_redirect_count <= r_redirect_count + PERF_W'(1);
    end
  end

  assign bus.stall_cycles_o   = r_stall_cycles;
  assign bus.flush_cycles_o   = r_flush_cycles;
  assign bus.redirect_count_o = r_redirect_count;
`endif

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed vector table, hand sequences around reset, and randomized traffic
// compared against a cycle-count reference model of the hazard rules.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic clk;
  logic rst_n;

  hazard_ctrl_if #(.NUM_SRC(4), .CNT_W(4)) bus ();

  hazard_ctrl #(.NUM_SRC(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Redirect together with a busy Execute unit must never be produced upstream.
  always @(posedge clk) begin
    if (rst_n)
      assert (!(bus.redirect_i && bus.mc_busy_i))
        else $error("illegal redirect_i while mc_busy_i");
  end

  typedef struct {
    logic [3:0]  req;
    logic [15:0] len;
    logic        busy;
    logic        redir;
    logic [5:0]  flags;  // {StallF, StallD, StallE, FlushD, FlushE, busy_o}
    logic [3:0]  src;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_pass;

  // reference model state: stall cycles still owed after this one, and owner
  int   m_rem;
  int   m_owner;

  task automatic add(input logic [3:0] req, input logic [15:0] len,
                     input logic busy, input logic redir,
                     input logic [5:0] flags, input logic [3:0] src);
    vec_t v;
    v.req = req; v.len = len; v.busy = busy; v.redir = redir;
    v.flags = flags; v.src = src;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [3:0] req, input logic [15:0] len,
                       input logic busy, input logic redir);
    bus.stall_req  = req;
    bus.stall_len  = len;
    bus.mc_busy_i  = busy;
    bus.redirect_i = redir;
  endtask

  function automatic logic [9:0] outs();
    return {bus.StallF, bus.StallD, bus.StallE, bus.FlushD, bus.FlushE,
            bus.busy_o, bus.hazard_src};
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got F D E fD fE bsy src=%b required %b", name, act, exp);
  endtask

  // randomized-phase locals
  logic [3:0]  r_req;
  logic [15:0] r_len;
  logic        r_busy, r_redir, m_red, m_stall;
  logic [3:0]  m_src;
  logic [9:0]  m_exp;
  len_t        m_len;
  int          m_win;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    drive(4'b0000, 16'h0000, 1'b0, 1'b0);
    #2;
    check("reset_state", outs(), 10'b0);
    drive(4'b1111, 16'h3333, 1'b0, 1'b1);
    #1;
    check("reset_forced_zero", outs(), 10'b0);
    drive(4'b0000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---------------- directed table ----------------
    // single-cycle stall, source 0, length 1
    add(4'b0001, 16'h0001, 0, 0, 6'b110010, 4'b0001);
    add(4'b0000, 16'h0000, 0, 0, 6'b000000, 4'b0000);
    // priority: source 1 (len 3) beats source 2 (len 5); held request ignored
    add(4'b0110, 16'h0530, 0, 0, 6'b110010, 4'b0010);
    add(4'b0110, 16'h0530, 0, 0, 6'b110011, 4'b0010);
    add(4'b0110, 16'h0530, 0, 0, 6'b110011, 4'b0010);
    add(4'b0000, 16'h0530, 0, 0, 6'b000000, 4'b0000);
    // length 4 with two busy cycles -> six stall cycles
    add(4'b1000, 16'h4000, 0, 0, 6'b110010, 4'b1000);
    add(4'b1000, 16'h4000, 1, 0, 6'b111001, 4'b1000);
    add(4'b1000, 16'h4000, 1, 0, 6'b111001, 4'b1000);
    add(4'b1000, 16'h4000, 0, 0, 6'b110011, 4'b1000);
    add(4'b1000, 16'h4000, 0, 0, 6'b110011, 4'b1000);
    add(4'b1000, 16'h4000, 0, 0, 6'b110011, 4'b1000);
    add(4'b0000, 16'h4000, 0, 0, 6'b000000, 4'b0000);
    // length 5 cancelled by redirect in its third cycle
    add(4'b0001, 16'h0005, 0, 0, 6'b110010, 4'b0001);
    add(4'b0001, 16'h0005, 0, 0, 6'b110011, 4'b0001);
    add(4'b0001, 16'h0005, 0, 1, 6'b000111, 4'b0000);
    add(4'b0000, 16'h0005, 0, 0, 6'b000000, 4'b0000);
    // length 0 behaves as length 1
    add(4'b0100, 16'h0000, 0, 0, 6'b110010, 4'b0100);
    add(4'b0000, 16'h0000, 0, 0, 6'b000000, 4'b0000);
    // back-to-back length-2 stalls with no gap
    add(4'b0010, 16'h0020, 0, 0, 6'b110010, 4'b0010);
    add(4'b0010, 16'h0020, 0, 0, 6'b110011, 4'b0010);
    add(4'b0010, 16'h0020, 0, 0, 6'b110010, 4'b0010);
    add(4'b0000, 16'h0020, 0, 0, 6'b110011, 4'b0010);
    add(4'b0000, 16'h0000, 0, 0, 6'b000000, 4'b0000);
    // redirect in IDLE beats a request; nothing latched
    add(4'b0001, 16'h0003, 0, 1, 6'b000110, 4'b0000);
    add(4'b0000, 16'h0003, 0, 0, 6'b000000, 4'b0000);
    // request while busy in IDLE is not latched
    add(4'b0001, 16'h0003, 1, 0, 6'b111000, 4'b0001);
    add(4'b0000, 16'h0003, 0, 0, 6'b000000, 4'b0000);
    // busy alone
    add(4'b0000, 16'h0000, 1, 0, 6'b111000, 4'b0000);
    add(4'b0000, 16'h0000, 0, 0, 6'b000000, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].req, vecs[i].len, vecs[i].busy, vecs[i].redir);
      @(negedge clk);
      $display("vec %0d req=%b len=%h busy=%b redir=%b out=%b", i,
               vecs[i].req, vecs[i].len, vecs[i].busy, vecs[i].redir, outs());
      check($sformatf("vec%0d", i), outs(), {vecs[i].flags, vecs[i].src});
      @(posedge clk); #1;
    end

    // ---------------- reset asserted mid-STALL ----------------
    drive(4'b0001, 16'h0005, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_seq_start", outs(), {6'b110010, 4'b0001});
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_seq_in_stall", outs(), {6'b110011, 4'b0001});
    #1 rst_n = 1'b0;
    #1;
    $display("reset asserted mid-stall out=%b", outs());
    check("rst_mid_stall", outs(), 10'b0);
    @(posedge clk); #1;
    check("rst_hold", outs(), 10'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0000, 16'h0000, 1'b0, 1'b0);
    #1;
    check("rst_release_idle", outs(), 10'b0);
    @(posedge clk); #1;
    drive(4'b0001, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    check("first_req_after_rst", outs(), {6'b110010, 4'b0001});
    @(posedge clk); #1;
    drive(4'b0000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    check("idle_after_single", outs(), 10'b0);

    // ---------------- randomized vs reference model ----------------
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_rem   = 0;
    m_owner = 0;
    @(posedge clk); #1;
    for (int t = 0; t < 400; t++) begin
      r_req   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
      r_len   = 16'($urandom) & 16'h7777;
      r_busy  = ($urandom_range(0, 4) == 0);
      r_redir = !r_busy && ($urandom_range(0, 9) == 0);

      m_red = r_redir & ~r_busy;
      m_win = -1;
      for (int s = 3; s >= 0; s--)
        if (r_req[s]) m_win = s;
      m_len = (m_win >= 0) ? r_len[m_win*4 +: 4] : len_t'(1);
      if (m_len == 0) m_len = 1;
      if (m_rem > 0) begin
        m_stall = 1'b1;
        m_src   = 4'(1 << m_owner);
      end else if (m_win >= 0) begin
        m_stall = 1'b1;
        m_src   = 4'(1 << m_win);
      end else begin
        m_stall = 1'b0;
        m_src   = 4'b0000;
      end
      m_exp = {(m_stall | r_busy) & ~m_red, (m_stall | r_busy) & ~m_red, r_busy,
               m_red, (m_stall & ~r_busy & ~m_red) | m_red, (m_rem > 0),
               m_red ? 4'b0000 : m_src};

      drive(r_req, r_len, r_busy, r_redir);
      @(negedge clk);
      $display("rnd %0d req=%b len=%h busy=%b redir=%b out=%b", t,
               r_req, r_len, r_busy, r_redir, outs());
      check($sformatf("rnd%0d", t), outs(), m_exp);

      if (m_red)
        m_rem = 0;
      else if (r_busy)
        m_rem = m_rem;
      else if (m_rem > 0)
        m_rem = m_rem - 1;
      else if (m_win >= 0) begin
        m_rem   = int'(m_len) - 1;
        m_owner = m_win;
      end
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_hazard_ctrl
